// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between the CPU and the loader/debug port.
// Define MEM_ARB_CPU_PRIORITY_EN for fixed CPU-wins-ties priority instead of round-robin.
module mem_port_arbiter #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int RAM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_wait,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_ack,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

  state_t              state_q, state_d;
  logic                win_ldr_q, win_ldr_d;
  logic [CNT_W-1:0]    lat_q, lat_d;
  logic                ram_en_q, ram_en_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                ldr_ack_q, ldr_ack_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   ldr_rdata_q, ldr_rdata_d;
  logic                pick_ldr;
  logic                done;

`ifdef MEM_ARB_CPU_PRIORITY_EN
  always_comb pick_ldr = ~cpu_req;
`else
  // last_ldr_q resets to 1 so the CPU wins the first tie.
  logic last_ldr_q, last_ldr_d;
  always_comb pick_ldr = ldr_req & (~cpu_req | ~last_ldr_q);
`endif

  always_comb begin
    state_d     = state_q;
    win_ldr_d   = win_ldr_q;
    lat_d       = lat_q;
    ram_en_d    = ram_en_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    cpu_ack_d   = 1'b0;
    ldr_ack_d   = 1'b0;
    cpu_rdata_d = '0;
    ldr_rdata_d = '0;
    done        = 1'b0;
`ifndef MEM_ARB_CPU_PRIORITY_EN
    last_ldr_d  = last_ldr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cpu_req || ldr_req) begin
          win_ldr_d   = pick_ldr;
          ram_en_d    = 1'b1;
          ram_we_d    = pick_ldr ? ldr_we    : cpu_we;
          ram_addr_d  = pick_ldr ? ldr_addr  : cpu_addr;
          ram_wdata_d = pick_ldr ? ldr_wdata : cpu_wdata;
          state_d     = S_ACCESS;
`ifndef MEM_ARB_CPU_PRIORITY_EN
          last_ldr_d  = pick_ldr;
`endif
        end
      end
      S_ACCESS: begin
        if (ram_we_q || RAM_LAT <= 1) begin
          done = 1'b1;
        end else begin
          // ACCESS already covers the first latency cycle.
          state_d = S_WAIT;
          lat_d   = CNT_W'(RAM_LAT - 2);
        end
      end
      S_WAIT: begin
        if (lat_q == '0) done = 1'b1;
        else             lat_d = lat_q - CNT_W'(1);
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Last RAM cycle: capture read data and route the ack to the winner.
    if (done) begin
      state_d  = S_RESP;
      ram_en_d = 1'b0;
      ram_we_d = 1'b0;
      if (win_ldr_q) begin
        ldr_ack_d   = 1'b1;
        ldr_rdata_d = ram_we_q ? '0 : ram_rdata;
      end else begin
        cpu_ack_d   = 1'b1;
        cpu_rdata_d = ram_we_q ? '0 : ram_rdata;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      win_ldr_q   <= 1'b0;
      lat_q       <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      ldr_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
`ifndef MEM_ARB_CPU_PRIORITY_EN
      last_ldr_q  <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      win_ldr_q   <= win_ldr_d;
      lat_q       <= lat_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      ldr_ack_q   <= ldr_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
`ifndef MEM_ARB_CPU_PRIORITY_EN
      last_ldr_q  <= last_ldr_d;
`endif
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_wait  = cpu_req & ~cpu_ack_q;
  assign ldr_ack   = ldr_ack_q;
  assign ldr_rdata = ldr_rdata_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule
